// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: FSM states,
// line levels, legal word widths and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL     = 1'b0;
    localparam logic STOP_LEVEL      = 1'b1;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    // Parity over a word zero-extended to the widest legal size; the padding
    // bits do not change the XOR. odd = 1 inverts the even result.
    function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] word,
                                        input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and strobes
// o_bit_end in the last cycle of each bit period. Shared with the receiver.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap at the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_end = i_en && !i_clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: configurable word width, LSB first, optional even/odd
// parity and one or two stop bits, fed through a valid/ready handshake.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_two_stop,
    output logic                 o_TX,
    output logic                 o_TX_Active,
    output logic                 o_TX_Done
);

    if (CLKS_PER_BIT < 2 || DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_param_check
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2 and DATA_BITS within 5..9");
    end

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 active_q, active_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 par_en_q, par_en_d;
    logic                 parity_q, parity_d;
    logic                 two_stop_q, two_stop_d;
    logic                 stop_cnt_q, stop_cnt_d;

    logic                 timer_clear;
    logic                 bit_end;

    // The timer sits at zero in IDLE so a fresh bit period starts on accept.
    assign timer_clear = (state_q == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk    (i_Clock),
        .i_rst    (i_Reset),
        .i_clear  (timer_clear),
        .i_en     (!timer_clear),
        .o_bit_end(bit_end)
    );

    // Frame sequencing: each transition also sets the line level for the next bit.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        active_d   = active_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        par_en_d   = par_en_q;
        parity_d   = parity_q;
        two_stop_d = two_stop_q;
        stop_cnt_d = stop_cnt_q;

        case (state_q)
            IDLE: begin
                tx_d     = UART_IDLE_LEVEL;
                active_d = 1'b0;
                ready_d  = 1'b1;
                if (i_valid && ready_q) begin
                    shift_d    = i_data;
                    par_en_d   = i_parity_en;
                    parity_d   = parity_bit(DATA_BITS_MAX'(i_data), i_parity_odd);
                    two_stop_d = i_two_stop;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = START;
                    tx_d       = START_LEVEL;
                    active_d   = 1'b1;
                    ready_d    = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = STOP;
                            tx_d       = STOP_LEVEL;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    tx_d       = STOP_LEVEL;
                    stop_cnt_d = 1'b0;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                        tx_d       = UART_IDLE_LEVEL;
                        active_d   = 1'b0;
                        ready_d    = 1'b1;
                        done_d     = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                tx_d       = UART_IDLE_LEVEL;
                active_d   = 1'b0;
                ready_d    = 1'b1;
                bit_idx_d  = '0;
                stop_cnt_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame without a done pulse.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            tx_q       <= UART_IDLE_LEVEL;
            active_q   <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            active_q   <= active_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            par_en_q   <= par_en_d;
            parity_q   <= parity_d;
            two_stop_q <= two_stop_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    assign o_TX        = tx_q;
    assign o_TX_Active = active_q;
    assign o_TX_Done   = done_q;
    assign o_ready     = ready_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with CLKS_PER_BIT = 4; an 8-bit and a
// 5-bit instance share the clock and reset.
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       two;
    logic       rdy;
    logic       tx;
    logic       act;
    logic       done;

    logic       v5;
    logic [4:0] d5;
    logic       rdy5;
    logic       tx5;
    logic       act5;
    logic       done5;

    int         n_checks = 0;
    int         n_errors = 0;

    logic [11:0] cap_bits;
    logic        cap_stable;
    int          cap_act;
    int          cap_done;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_valid     (valid),
        .o_ready     (rdy),
        .i_data      (data),
        .i_parity_en (pen),
        .i_parity_odd(podd),
        .i_two_stop  (two),
        .o_TX        (tx),
        .o_TX_Active (act),
        .o_TX_Done   (done)
    );

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(5)) dut5 (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_valid     (v5),
        .o_ready     (rdy5),
        .i_data      (d5),
        .i_parity_en (1'b0),
        .i_parity_odd(1'b0),
        .i_two_stop  (1'b0),
        .o_TX        (tx5),
        .o_TX_Active (act5),
        .o_TX_Done   (done5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one word for a single accept edge.
    task automatic send(input bit sel, input logic [7:0] w, input logic p_en,
                        input logic p_odd, input logic two_s);
        @(negedge clk);
        check("rdy_before_send", sel ? rdy5 : rdy, 1'b1);
        if (sel) begin
            d5 = w[4:0];
            v5 = 1'b1;
        end else begin
            data  = w;
            pen   = p_en;
            podd  = p_odd;
            two   = two_s;
            valid = 1'b1;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        v5    = 1'b0;
    endtask

    // Sample nbits bit periods starting with the next falling edge.
    task automatic capture(input bit sel, input int nbits);
        logic s;
        cap_bits   = '0;
        cap_stable = 1'b1;
        cap_act    = 0;
        cap_done   = 0;
        for (int c = 0; c < nbits * CPB; c++) begin
            @(negedge clk);
            s = sel ? tx5 : tx;
            if (c % CPB == 0) cap_bits[c / CPB] = s;
            else if (s !== cap_bits[c / CPB]) cap_stable = 1'b0;
            if (sel ? act5 : act) cap_act++;
            if (sel ? done5 : done) cap_done++;
        end
    endtask

    // Check a captured frame and the done cycle that follows it.
    task automatic verify(input string tag, input bit sel, input int nbits,
                          input logic [11:0] exp_bits);
        check({tag, "_bits"}, cap_bits, exp_bits);
        check({tag, "_stable"}, cap_stable, 1'b1);
        check({tag, "_active_cycles"}, cap_act, nbits * CPB);
        check({tag, "_done_in_frame"}, cap_done, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, sel ? done5 : done, 1'b1);
        check({tag, "_active_after"}, sel ? act5 : act, 1'b0);
        check({tag, "_ready_after"}, sel ? rdy5 : rdy, 1'b1);
        check({tag, "_tx_after"}, sel ? tx5 : tx, 1'b1);
    endtask

    task automatic run_frame(input string tag, input bit sel, input logic [7:0] w,
                             input logic p_en, input logic p_odd, input logic two_s,
                             input int nbits, input logic [11:0] exp_bits);
        send(sel, w, p_en, p_odd, two_s);
        capture(sel, nbits);
        verify(tag, sel, nbits, exp_bits);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, sel ? done5 : done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lows;
        int dones;
        int acts;

        rst = 1'b1; valid = 1'b0; data = '0; pen = 1'b0; podd = 1'b0; two = 1'b0;
        v5 = 1'b0; d5 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_active", act, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ready", rdy, 1'b1);
        check("reset_tx5", tx5, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0x55 8N1: line 0,1,0,1,0,1,0,1,0,1
        run_frame("t1_55", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 10, 12'h2AA);

        // 0xA3 even parity -> parity 0; odd -> parity 1
        run_frame("t2_even", 1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 11, 12'h546);
        run_frame("t2_odd", 1'b0, 8'hA3, 1'b1, 1'b1, 1'b0, 11, 12'h746);

        // 0xFF two stop bits: 44 cycles, last 8 high
        run_frame("t3_ff2s", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 11, 12'h7FE);

        // Back-to-back 0x12 then 0x34 with i_valid held
        @(negedge clk);
        data = 8'h12; pen = 1'b0; podd = 1'b0; two = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1;
        data = 8'h34;
        capture(1'b0, 10);
        verify("t4_first", 1'b0, 10, 12'h224);
        @(posedge clk);
        #1;
        valid = 1'b0;
        capture(1'b0, 10);
        verify("t4_second", 1'b0, 10, 12'h268);
        @(negedge clk);
        check("t4_done_one_cycle", done, 1'b0);

        // Reset during data bit 3 of 0x55
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        check("t5_tx_data_bit3", tx, 1'b0);
        check("t5_active_mid", act, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_tx_after_rst", tx, 1'b1);
        check("t5_active_after_rst", act, 1'b0);
        check("t5_ready_after_rst", rdy, 1'b1);
        dones = 0; lows = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (!tx) lows++;
        end
        check("t5_no_done", dones, 0);
        check("t5_line_idle", lows, 0);

        // i_valid pulse and input changes while busy are ignored
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        fork
            capture(1'b0, 10);
            begin
                repeat (12) @(negedge clk);
                check("t6_ready_busy", rdy, 1'b0);
                data = 8'h00; pen = 1'b1; valid = 1'b1;
                @(negedge clk);
                check("t6_ready_busy2", rdy, 1'b0);
                data = 8'hFF; pen = 1'b0;
                @(negedge clk);
                valid = 1'b0;
            end
        join
        verify("t6_inflight", 1'b0, 10, 12'h2AA);
        lows = 0; acts = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!tx) lows++;
            if (act) acts++;
        end
        check("t6_no_extra_low", lows, 0);
        check("t6_no_extra_active", acts, 0);

        // DATA_BITS = 5, word 0x15: 7-bit frame, 28 cycles
        run_frame("t7_5bit", 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 7, 12'h06A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It serialises a word of configurable width, LSB first. Per frame it can add optional even or odd parity and one or two stop bits. Words are accepted through a valid/ready handshake, so an upstream FIFO or sequencer can stream frames back to back. It sits between the board-level control/data path and the TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period; equals i_Clock frequency / baud rate; must be >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
i_Clock  input  1  system clock; all logic is on the rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_valid  input  1  upstream has a word to send.
o_ready  output 1  block can accept a word (high only in IDLE).
i_data  input  DATA_BITS  word to send; sampled on accept.
i_parity_en  input  1  1 = insert a parity bit; sampled on accept.
i_parity_odd  input  1  1 = odd parity, 0 = even; sampled on accept.
i_two_stop  input  1  1 = two stop bits, 0 = one; sampled on accept.
o_TX  output 1  serial line; idles high.
o_TX_Active  output 1  high from the first start-bit cycle through the last stop-bit cycle.
o_TX_Done  output 1  one-cycle pulse when a frame completes.

Behaviour:
- Reset is the only clear. One clock and one reset. While i_Reset = 1 at an edge:
  - o_TX = 1, o_TX_Active = 0, o_TX_Done = 0.
  - o_ready = 1 from the following cycle.
  - State = IDLE; all counters are 0; the shift register and latched mode bits are 0.
- Accept: an edge where i_valid & o_ready = 1. At that edge the block:
  - latches i_data, parity_en, parity_odd and two_stop;
  - sets state = START, o_TX = 0, o_TX_Active = 1, o_ready = 0.
- Latency: o_TX goes low in the cycle immediately after the accept edge.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - PARITY is entered only if parity_en was latched.
  - STOP runs for 1 or 2 bit periods, according to the latched two_stop.
- Bit timing:
  - Every bit is driven for exactly CLKS_PER_BIT cycles.
  - The bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Timer width is clog2(CLKS_PER_BIT).
- Data bits: sent LSB first. The bit index runs 0..DATA_BITS-1 and is cleared on leaving DATA.
- Parity bit:
  - Even: XOR of the latched data bits.
  - Odd: the inverted XOR.
  - Computed from the latched word, not the live i_data.
- Frame length in cycles = (1 + DATA_BITS + P + S) * CLKS_PER_BIT, where P is 0 or 1 and S is 1 or 2.
- End of frame: at the edge that ends the last stop bit:
  - state = IDLE, o_TX_Active = 0, o_ready = 1;
  - o_TX_Done = 1 for exactly that one following cycle;
  - o_TX stays 1.
- Back-to-back: if i_valid is held high, the next accept happens in the o_TX_Done cycle. The next start bit therefore follows after exactly one idle-high clock.
- i_valid while busy: ignored, no queueing. Changes to i_data or mode inputs mid-frame have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted at that edge.
  - o_TX = 1, o_TX_Active = 0.
  - No o_TX_Done pulse.
  - The partial word is discarded.
- Illegal state encodings recover to IDLE with o_TX = 1.
- Elaboration check: fail if CLKS_PER_BIT < 2 or DATA_BITS is outside 5..9.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants UART_IDLE_LEVEL = 1, START_LEVEL = 0, STOP_LEVEL = 1;
  - DATA_BITS_MIN/MAX.
- One sub-module, uart_bit_timer:
  - parametrised by CLKS_PER_BIT;
  - inputs: clear and enable; output: a one-cycle bit_end strobe;
  - intended for reuse by the companion receiver.

Test Plan (CLKS_PER_BIT = 4, DATA_BITS = 8 unless noted):
1. Accept 0x55, no parity, 1 stop -> o_TX reads 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total); o_TX_Done pulses once in cycle 41; o_TX_Active is high for 40 cycles.
2. Accept 0xA3 with even parity -> data bits 1,1,0,0,0,1,0,1, then parity 0. Repeat with odd parity -> parity bit 1. Both frames are 44 cycles.
3. Accept 0xFF, no parity, two stop -> 44-cycle frame; the line is high for the final 8 cycles before o_TX_Done.
4. Hold i_valid with 0x12 then 0x34 -> the second start bit begins exactly 1 cycle after the first o_TX_Done; both words decode correctly.
5. Assert i_Reset for 1 cycle during data bit 3 -> next cycle: o_TX = 1, o_TX_Active = 0, o_ready = 1; no o_TX_Done pulse.
6. Pulse i_valid with 0x00 mid-frame and toggle i_data and i_parity_en -> o_ready stays 0, the in-flight frame is unchanged, and no extra frame is sent. Also rerun test 1 with DATA_BITS = 5 and word 0x15 -> 7-bit frame, 28 cycles.
